// File: rtl/dm_serv_pkg.sv
// rtl/dm_serv_pkg.sv - shared types and error codes for the serv debug module SBA engine
package dm_serv_pkg;

    typedef enum logic [2:0] {
        Idle,
        Read,
        Write,
        WaitRead,
        WaitWrite
    } sba_state_e;

    typedef struct packed {
        logic       sbreadonaddr;
        logic [2:0] sbaccess;
        logic       sbautoincrement;
        logic       sbreadondata;
    } sbcs_t;

    localparam logic [2:0] SbErrNone    = 3'd0;
    localparam logic [2:0] SbErrTimeout = 3'd1;
    localparam logic [2:0] SbErrAlign   = 3'd3;
    localparam logic [2:0] SbErrSize    = 3'd4;
    localparam logic [2:0] SbErrOther   = 3'd7;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dm_serv_sba_lane.sv
// rtl/dm_serv_sba_lane.sv - byte-lane steering: wdata replication, byte enables, rdata alignment
module dm_serv_sba_lane
    import dm_serv_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic [BusWidth-1:0]   wdata_in,
    input  logic [BusWidth-1:0]   rdata_in,
    output logic [BusWidth-1:0]   wdata,
    output logic [BusWidth/8-1:0] be,
    output logic [BusWidth-1:0]   rdata
);

    logic [BusWidth-1:0] rshift;

    assign be     = (BusWidth/8)'(size_mask(size)) << offset;
    assign rshift = rdata_in >> {offset, 3'b000};

    always_comb begin
        wdata = wdata_in;
        rdata = rshift;
        case (size)
            2'd0: begin
                wdata = {4{wdata_in[7:0]}};
                rdata = {24'b0, rshift[7:0]};
            end
            2'd1: begin
                wdata = {2{wdata_in[15:0]}};
                rdata = {16'b0, rshift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_serv_sba.sv
// rtl/dm_serv_sba.sv - SBA engine; DM_SERV_SBA_TIMEOUT_EN enables the 16-bit response timeout
module dm_serv_sba
    import dm_serv_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic                  sbbusy_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic                  master_r_err_i
);

    sba_state_e          state_q, state_d;
    sbcs_t               sbcs;
    logic [BusWidth-1:0] addr_q, wdata_q, eff_addr, rdata_aligned, inc;
    logic [1:0]          size_q;
    logic                soft_rst, go_read, go_write, start;
    logic                size_err, align_err, req_err, in_wait, rsp_done, timeout_hit;

    assign sbcs = '{sbreadonaddr: sbreadonaddr_i, sbaccess: sbaccess_i,
                    sbautoincrement: sbautoincrement_i, sbreadondata: sbreadondata_i};

    // dmactive low is treated exactly like the synchronous reset
    assign soft_rst = !rst_ni || !dmactive_i;

    // Address write has priority and masks the data strobes in the same cycle
    assign go_read   = sbaddress_write_valid_i ? sbcs.sbreadonaddr
                     : (!sbdata_write_valid_i && sbdata_read_valid_i && sbcs.sbreadondata);
    assign go_write  = !sbaddress_write_valid_i && sbdata_write_valid_i;
    assign start     = go_read || go_write;
    assign eff_addr  = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    assign size_err  = sbcs.sbaccess > 3'd2;
    assign align_err = (sbcs.sbaccess == 3'd1 && eff_addr[0]) ||
                       (sbcs.sbaccess == 3'd2 && |eff_addr[1:0]);
    assign req_err   = start && (size_err || align_err);
    assign in_wait   = (state_q == WaitRead) || (state_q == WaitWrite);
    assign rsp_done  = in_wait && master_r_valid_i;
    assign inc       = BusWidth'(1) << size_q;

`ifdef DM_SERV_SBA_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (soft_rst || !in_wait) tmo_cnt_q <= '0;
        else                      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    assign timeout_hit = in_wait && (&tmo_cnt_q) && !master_r_valid_i;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (soft_rst) state_q <= Idle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle:      if (start && !req_err) state_d = go_read ? Read : Write;
            Read:      if (master_gnt_i) state_d = WaitRead;
            Write:     if (master_gnt_i) state_d = WaitWrite;
            WaitRead,
            WaitWrite: if (master_r_valid_i || timeout_hit) state_d = Idle;
            default:   state_d = Idle;
        endcase
    end

    always_comb begin
        master_req_o = 1'b0;
        master_we_o  = 1'b0;
        sbbusy_o     = (state_q != Idle);
        case (state_q)
            Read:  master_req_o = dmactive_i;
            Write: begin
                master_req_o = dmactive_i;
                master_we_o  = dmactive_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            addr_q          <= '0;
            wdata_q         <= '0;
            size_q          <= '0;
            sbdata_o        <= '0;
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o       <= SbErrNone;
        end else begin
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o       <= SbErrNone;
            if (state_q == Idle) begin
                if (sbaddress_write_valid_i) addr_q <= sbaddress_i;
                if (go_write)                wdata_q <= sbdata_i;
                if (req_err) begin
                    sberror_valid_o <= 1'b1;
                    sberror_o       <= size_err ? SbErrSize : SbErrAlign;
                end else if (start) begin
                    size_q <= sbcs.sbaccess[1:0];
                end
            end else if (timeout_hit) begin
                sberror_valid_o <= 1'b1;
                sberror_o       <= SbErrTimeout;
            end else if (rsp_done) begin
                if (master_r_err_i) begin
                    sberror_valid_o <= 1'b1;
                    sberror_o       <= SbErrOther;
                end else begin
                    if (state_q == WaitRead) begin
                        sbdata_o       <= rdata_aligned;
                        sbdata_valid_o <= 1'b1;
                    end
                    if (sbcs.sbautoincrement) addr_q <= addr_q + inc;
                end
            end
        end
    end

    dm_serv_sba_lane #(.BusWidth(BusWidth)) u_lane (
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .wdata_in (wdata_q),
        .rdata_in (master_r_rdata_i),
        .wdata    (master_wdata_o),
        .be       (master_be_o),
        .rdata    (rdata_aligned)
    );

    assign master_add_o = {addr_q[BusWidth-1:2], 2'b00};
    assign sbaddress_o  = addr_q;

endmodule
